// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, synchronous-read memory between two requesters:
//   port A - CPU fetch / load-store path
//   port B - memory loader / debug port
//
// Each granted transaction takes exactly three cycles:
//   S_IDLE    : requests are sampled, the winner's command is latched
//   S_ACCESS  : latched command is driven onto the memory bus
//   S_RESPOND : memory read data is returned, owner's ack pulses
// Requests are only looked at in S_IDLE, so back-to-back transactions are
// spaced three cycles apart and the memory bus never sees a half-latched
// command.
//
// Handshake: a requester raises req with wr/addr/wr_data stable and keeps req
// high until it sees ack (a one-cycle pulse in S_RESPOND). req still high in
// the following S_IDLE is taken as a fresh request. gnt marks the two cycles
// in which the port owns the memory.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_req/a_wr/a_addr/a_wr_data   port A command inputs
//   a_gnt/a_ack/a_rd_data         port A status and read data
//   b_*                           same set for port B
//   mem_addr/mem_wr/mem_wr_data   memory command bus
//   mem_rd_data                   memory read data, valid one cycle after addr
//   busy                          high whenever a transaction is in flight
//   state_dbg                     current FSM state, for observation only
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 a_req,
  input  logic                 a_wr,
  input  logic [AddrWidth-1:0] a_addr,
  input  logic [DataWidth-1:0] a_wr_data,
  output logic                 a_gnt,
  output logic                 a_ack,
  output logic [DataWidth-1:0] a_rd_data,

  input  logic                 b_req,
  input  logic                 b_wr,
  input  logic [AddrWidth-1:0] b_addr,
  input  logic [DataWidth-1:0] b_wr_data,
  output logic                 b_gnt,
  output logic                 b_ack,
  output logic [DataWidth-1:0] b_rd_data,

  output logic [AddrWidth-1:0] mem_addr,
  output logic                 mem_wr,
  output logic [DataWidth-1:0] mem_wr_data,
  input  logic [DataWidth-1:0] mem_rd_data,

  output logic                 busy,
  output logic [1:0]           state_dbg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic                 owner;       // port that owns the current transaction
  logic                 last;        // port that was served most recently
  logic                 win;         // arbitration result for this cycle
  logic                 any_req;
  logic                 lat_wr;
  logic [AddrWidth-1:0] lat_addr;
  logic [DataWidth-1:0] lat_wr_data;
  logic [DataWidth-1:0] a_hold;
  logic [DataWidth-1:0] b_hold;
  logic                 in_access;
  logic                 in_respond;
  logic                 in_txn;

  assign any_req    = a_req | b_req;
  assign in_access  = (state == S_ACCESS);
  assign in_respond = (state == S_RESPOND);
  assign in_txn     = in_access | in_respond;

  // Round robin: on contention the port that was not served last wins.
  // last resets to B so that A wins the first contended grant.
  always_comb begin
    win = PORT_A;
    if (a_req && b_req) begin
      win = (last == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req) begin
      win = PORT_B;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (any_req) state_nxt = S_ACCESS;
      S_ACCESS:  state_nxt = S_RESPOND;
      S_RESPOND: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command latch: captured once per transaction, so requester inputs may
  // change freely after the sampling edge without disturbing the memory bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= PORT_A;
      lat_wr      <= 1'b0;
      lat_addr    <= '0;
      lat_wr_data <= '0;
    end else if (state == S_IDLE && any_req) begin
      owner       <= win;
      lat_wr      <= (win == PORT_B) ? b_wr      : a_wr;
      lat_addr    <= (win == PORT_B) ? b_addr    : a_addr;
      lat_wr_data <= (win == PORT_B) ? b_wr_data : a_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= PORT_B;
    end else if (in_access) begin
      last <= owner;
    end
  end

  // Per-port read data hold registers; only that port's reads update them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold <= '0;
      b_hold <= '0;
    end else if (in_respond && !lat_wr) begin
      if (owner == PORT_A) begin
        a_hold <= mem_rd_data;
      end else begin
        b_hold <= mem_rd_data;
      end
    end
  end

  // Memory bus. mem_wr is decoded from state so an asynchronous reset
  // removes the write strobe immediately.
  assign mem_addr    = lat_addr;
  assign mem_wr_data = lat_wr_data;
  assign mem_wr      = in_access & lat_wr;

  assign a_gnt = in_txn & (owner == PORT_A);
  assign b_gnt = in_txn & (owner == PORT_B);
  assign a_ack = in_respond & (owner == PORT_A);
  assign b_ack = in_respond & (owner == PORT_B);

  // During the owner's read response the live memory data is forwarded so
  // the requester can use it in the ack cycle itself.
  assign a_rd_data = (in_respond && owner == PORT_A && !lat_wr) ? mem_rd_data : a_hold;
  assign b_rd_data = (in_respond && owner == PORT_B && !lat_wr) ? mem_rd_data : b_hold;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives both requesters with directed and random transactions. A
// transaction-level model decides, at each clock edge, which pending request
// the arbiter must accept and what it must return; accepted transactions are
// pushed into exp_q. A monitor on the falling edge pops them and compares
// every control output, the memory bus and both read data ports.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 8;

  typedef struct {
    int unsigned   s;      // edge at which the request is accepted
    bit            port;   // 0 = A, 1 = B
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rd;     // expected read data (reads only)
  } txn_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst_n;
  logic          a_req, a_wr, b_req, b_wr;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wr_data, b_wr_data;
  logic          a_gnt, a_ack, b_gnt, b_ack;
  logic [DW-1:0] a_rd_data, b_rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          busy;
  logic [1:0]    state_dbg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mem_arbiter #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_req      (a_req),
    .a_wr       (a_wr),
    .a_addr     (a_addr),
    .a_wr_data  (a_wr_data),
    .a_gnt      (a_gnt),
    .a_ack      (a_ack),
    .a_rd_data  (a_rd_data),
    .b_req      (b_req),
    .b_wr       (b_wr),
    .b_addr     (b_addr),
    .b_wr_data  (b_wr_data),
    .b_gnt      (b_gnt),
    .b_ack      (b_ack),
    .b_rd_data  (b_rd_data),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- memory (environment) ----------------
  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return 16'h1234;
    return 16'((i * 257) ^ 16'hA5C3);
  endfunction

  logic [DW-1:0] mem [0:255];
  logic          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else begin
      if (mem_wr) mem[mem_addr] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr];
    end
  end

  // ---------------- scoreboard state ----------------
  int          n_compared   = 0;
  int          n_mismatched = 0;
  txn_t        exp_q[$];
  int unsigned edge_n       = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Rules: a request is accepted at an edge when the arbiter is free (three
  // edges after the previous acceptance); on contention the port not served
  // last wins, starting with A after reset. Reads return the latest written
  // value of the shadow memory.
  logic [DW-1:0] ref_mem [0:255];
  bit            ref_init   = 1'b0;
  int unsigned   free_edge  = 0;
  bit            m_last     = 1'b1;

  always @(posedge clk) begin
    txn_t t;
    bit   w;
    edge_n++;
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      ref_init = 1'b1;
    end
    if (!rst_n) begin
      exp_q.delete();
      free_edge = 0;
      m_last    = 1'b1;
    end else if (edge_n >= free_edge && (a_req || b_req)) begin
      w      = (a_req && b_req) ? !m_last : b_req;
      t.s    = edge_n;
      t.port = w;
      t.wr   = w ? b_wr : a_wr;
      t.addr = w ? b_addr : a_addr;
      t.data = w ? b_wr_data : a_wr_data;
      t.rd   = t.wr ? '0 : ref_mem[t.addr];
      if (t.wr) ref_mem[t.addr] = t.data;
      exp_q.push_back(t);
      free_edge = edge_n + 3;
      m_last    = w;
    end
  end

  // ---------------- monitor ----------------
  logic [DW-1:0] m_a_hold = '0;
  logic [DW-1:0] m_b_hold = '0;

  always @(negedge clk) begin
    txn_t          t;
    logic [5:0]    exp_ctl;
    logic [DW-1:0] exp_a_rd;
    logic [DW-1:0] exp_b_rd;
    if (!rst_n) begin
      m_a_hold = '0;
      m_b_hold = '0;
      check("reset_ctl", 32'({busy, a_gnt, b_gnt, a_ack, b_ack, mem_wr}), 32'd0);
      check("reset_bus", 32'({mem_addr, mem_wr_data}), 32'd0);
      check("reset_rd", {a_rd_data, b_rd_data}, 32'd0);
    end else begin
      exp_ctl  = 6'd0;
      exp_a_rd = m_a_hold;
      exp_b_rd = m_b_hold;
      if (exp_q.size() > 0 && edge_n == exp_q[0].s) begin
        t = exp_q[0];
        exp_ctl = {1'b1, !t.port, t.port, 1'b0, 1'b0, t.wr};
        check("access_addr", 32'(mem_addr), 32'(t.addr));
        if (t.wr) check("access_wdata", 32'(mem_wr_data), 32'(t.data));
      end else if (exp_q.size() > 0 && edge_n == exp_q[0].s + 1) begin
        t = exp_q.pop_front();
        exp_ctl = {1'b1, !t.port, t.port, !t.port, t.port, 1'b0};
        check("respond_addr", 32'(mem_addr), 32'(t.addr));
        if (!t.wr) begin
          if (t.port) exp_b_rd = t.rd;
          else        exp_a_rd = t.rd;
        end
      end
      check("ctl_busy_gnt_ack_wr", 32'({busy, a_gnt, b_gnt, a_ack, b_ack, mem_wr}), 32'(exp_ctl));
      check("a_rd_data", 32'(a_rd_data), 32'(exp_a_rd));
      check("b_rd_data", 32'(b_rd_data), 32'(exp_b_rd));
      m_a_hold = exp_a_rd;
      m_b_hold = exp_b_rd;
    end
  end

  // ---------------- driver tasks ----------------
  // Raises (or keeps) req with the given command, waits for ack, and returns
  // just after the edge that ends the ack cycle. keep=1 leaves req high so
  // the next call issues a back-to-back request.
  task automatic do_txn(input bit p, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input bit keep);
    bit seen;
    seen = 1'b0;
    if (!p) begin
      a_wr = wr; a_addr = addr; a_wr_data = data; a_req = 1'b1;
    end else begin
      b_wr = wr; b_addr = addr; b_wr_data = data; b_req = 1'b1;
    end
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = p ? b_ack : a_ack;
    end
    check(p ? "b_ack_seen" : "a_ack_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (!p) a_req = 1'b0;
      else    b_req = 1'b0;
    end
  endtask

  task automatic rand_port(input bit p, input int n);
    int g;
    bit keep;
    for (int i = 0; i < n; i++) begin
      g    = $urandom_range(0, 3);
      keep = (g == 0) && (i != n - 1);
      do_txn(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom), keep);
      if (!keep && g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wr_data = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wr_data = '0;
    #300;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Single read from A, data must persist after req drops.
    idle_cycles(2);
    do_txn(1'b0, 1'b0, 8'h05, 16'h0000, 1'b0);
    idle_cycles(3);

    // B writes, then A reads the same location back.
    do_txn(1'b1, 1'b1, 8'h0A, 16'hBEEF, 1'b0);
    idle_cycles(2);
    do_txn(1'b0, 1'b0, 8'h0A, 16'h0000, 1'b0);
    idle_cycles(2);

    // Simultaneous requests right after reset, both held continuously.
    pulse_reset(2);
    idle_cycles(1);
    fork
      begin
        do_txn(1'b0, 1'b0, 8'h0A, 16'h0000, 1'b1);
        do_txn(1'b0, 1'b1, 8'h07, 16'h1111, 1'b1);
        do_txn(1'b0, 1'b0, 8'h07, 16'h0000, 1'b0);
      end
      begin
        do_txn(1'b1, 1'b0, 8'h05, 16'h0000, 1'b1);
        do_txn(1'b1, 1'b1, 8'h05, 16'h2222, 1'b1);
        do_txn(1'b1, 1'b0, 8'h07, 16'h0000, 1'b0);
      end
    join
    idle_cycles(3);

    // Reset in the middle of a write's access cycle.
    a_wr = 1'b1; a_addr = 8'hF0; a_wr_data = 16'hDEAD; a_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_async", 32'({busy, a_gnt, a_ack, mem_wr}), 32'd0);
    a_req = 1'b0; a_wr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);

    // B request that lives only inside an A transaction is ignored.
    fork
      do_txn(1'b0, 1'b0, 8'h03, 16'h0000, 1'b0);
      begin
        for (int k = 0; k < 20 && !a_gnt; k++) @(negedge clk);
        b_wr = 1'b1; b_addr = 8'h03; b_wr_data = 16'h0BAD; b_req = 1'b1;
        @(negedge clk);
        b_req = 1'b0; b_wr = 1'b0;
      end
    join
    idle_cycles(3);

    // A alone holding req: re-granted every three cycles.
    do_txn(1'b0, 1'b0, 8'h01, 16'h0000, 1'b1);
    do_txn(1'b0, 1'b1, 8'h02, 16'h5555, 1'b1);
    do_txn(1'b0, 1'b0, 8'h02, 16'h0000, 1'b0);
    idle_cycles(3);

    // Random traffic on both ports.
    fork
      rand_port(1'b0, 25);
      rand_port(1'b1, 25);
    join
    idle_cycles(10);
    check("drain_exp_q", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the CPU's single-port, synchronous-read program/data memory.
- Requester A is the CPU fetch/load-store path. Requester B is the memory loader/debug port that fills or inspects memory while the CPU is held.
- Round-robin grant, a fixed 3-cycle transaction, and a registered req/ack handshake per port.
- Sits between the CPU control matrix, the loader, and the memory block.

Parameters:
DataWidth, 16, memory word width.
AddrWidth, 8, memory address width.

Ports:
Clk  input  1  system clock, all state changes on posedge.
Reset  input  1  asynchronous active-low reset.
A_Req  input  1  port A request; held high until A_Ack seen.
A_Wr  input  1  port A: 1=write, 0=read; stable while A_Req high.
A_Addr  input  AddrWidth  port A address.
A_WrData  input  DataWidth  port A write data.
A_Gnt  output  1  port A owns memory (S_Access and S_Respond).
A_Ack  output  1  one-cycle completion pulse for port A.
A_RdData  output  DataWidth  port A read data.
B_Req, B_Wr, B_Addr, B_WrData, B_Gnt, B_Ack, B_RdData: same as port A, for port B.
MemAddr  output  AddrWidth  address to memory.
MemWr  output  1  memory write strobe.
MemWrData  output  DataWidth  data to memory.
MemRdData  input  DataWidth  memory read data, valid the cycle after address is presented.
Busy  output  1  high whenever state != S_Idle.

Behaviour:

Reset (Reset=0, asynchronous):
- state=S_Idle, last=B; all Gnt/Ack/MemWr/Busy=0; MemAddr, MemWrData, A_RdData, B_RdData=0.
- A reset asserted mid-transaction aborts it immediately. MemWr drops without waiting for a clock; no Ack is issued; latched request is discarded.

States: S_Idle, S_Access, S_Respond.

S_Idle:
- If A_Req or B_Req is high at posedge: pick a winner, latch its Wr/Addr/WrData into internal regs, set owner, go to S_Access.
- With both requesting, the winner is the port not equal to last (after reset A wins first).
- With a single requester, that requester wins.

S_Access:
- MemAddr/MemWrData come from the latched regs; MemWr = latched Wr; owner's Gnt=1.
- Memory captures the access at the end of this cycle.
- Unconditional transition to S_Respond. last <= owner.

S_Respond:
- Owner's Gnt=1 and Ack=1 (this is the only cycle Ack is high); MemWr=0; MemAddr is held.
- On a read, owner's RdData = MemRdData combinationally during this cycle, and is captured into the owner's hold register at the posedge.
- Unconditional transition to S_Idle.

RdData and Ack details:
- Outside S_Respond, each RdData presents its hold register. Hold registers change only on that port's reads; writes leave them unchanged.
- The non-owner port's Ack/Gnt stay 0 throughout.

Requester rules:
- Req is sampled only in S_Idle; Req changes in other states are ignored.
- The requester deasserts Req at the posedge ending its Ack cycle.
- A Req still high in S_Idle after an Ack is a new request.

Timing:
- Latency from Req sampled high in S_Idle to Ack is 2 cycles; minimum spacing between transactions is 3 cycles.
- A port that keeps Req high continuously while the other also requests alternates with it: A, B, A, B…

No arithmetic. Address/data pass through unmodified. No wrap logic.

Test Plan:
1. Reset low 300 ns, then release. Outputs must be 0 and Busy=0. A_Req=1, A_Wr=0, A_Addr=8'h05 with mem[5]=16'h1234 -> A_Gnt high 2 cycles, A_Ack high exactly 1 cycle 2 cycles after sampling, A_RdData=16'h1234 and held after Req drops.
2. B write: B_Wr=1, B_Addr=8'h0A, B_WrData=16'hBEEF -> MemWr high exactly the S_Access cycle with MemAddr=8'h0A. A subsequent A read of 8'h0A returns 16'hBEEF. A_RdData unchanged by the B write until A's own read.
3. A_Req and B_Req asserted in the same cycle right after reset -> A granted first, then B. Both held continuously for 6 transactions -> order A,B,A,B,A,B; Acks never overlap.
4. Reset asserted during S_Access of a write -> MemWr falls asynchronously, no Ack, state=S_Idle. The memory location is not required to change; the bench must not check it.
5. B_Req pulsed high only during an A transaction (S_Access/S_Respond) and low before S_Idle -> B is never granted, B_Ack stays 0.
6. A_Req held high through A_Ack and the following S_Idle, B idle -> A re-granted. A_Ack pulses every 3 cycles; Busy is low for exactly 1 cycle between transactions.
